// File: rtl/spi_nor_pkg.sv
// Shared opcodes, FSM state encoding and address-phase length for the SPI NOR
// flash model and its controller.
package spi_nor_pkg;

  localparam logic [7:0] OP_READ    = 8'h01;
  localparam logic [7:0] OP_PROGRAM = 8'h02;
  localparam logic [7:0] OP_WREN    = 8'h06;

  localparam int ADDR_BYTES = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_IGNORE
  } state_e;

endpackage

// File: rtl/spi_nor_sync_edge.sv
// Brings the SPI pins into the p_clk domain (2-FF synchronizers) and detects
// s_clk rising edges (beats) and s_css edges.
module spi_nor_sync_edge #(
  parameter int W = 8
) (
  input  logic         p_clk,
  input  logic         p_reset,
  input  logic         s_clk,
  input  logic         s_css,
  input  logic [W-1:0] s_mosi,
  output logic [W-1:0] mosi_sync,
  output logic         beat,
  output logic         cs_rise,
  output logic         cs_fall
);

  logic         clk_meta_q, clk_meta_d, clk_sync_q, clk_sync_d, clk_prev_q, clk_prev_d;
  logic         css_meta_q, css_meta_d, css_sync_q, css_sync_d, css_prev_q, css_prev_d;
  logic [W-1:0] mosi_meta_q, mosi_meta_d, mosi_sync_q, mosi_sync_d;

  always_comb begin
    clk_meta_d  = s_clk;
    clk_sync_d  = clk_meta_q;
    clk_prev_d  = clk_sync_q;
    css_meta_d  = s_css;
    css_sync_d  = css_meta_q;
    css_prev_d  = css_sync_q;
    mosi_meta_d = s_mosi;
    mosi_sync_d = mosi_meta_q;
  end

  // Chip select resets to the deselected level so reset release is not a fall.
  always_ff @(posedge p_clk or posedge p_reset) begin
    if (p_reset) begin
      clk_meta_q  <= 1'b0;
      clk_sync_q  <= 1'b0;
      clk_prev_q  <= 1'b0;
      css_meta_q  <= 1'b1;
      css_sync_q  <= 1'b1;
      css_prev_q  <= 1'b1;
      mosi_meta_q <= '0;
      mosi_sync_q <= '0;
    end else begin
      clk_meta_q  <= clk_meta_d;
      clk_sync_q  <= clk_sync_d;
      clk_prev_q  <= clk_prev_d;
      css_meta_q  <= css_meta_d;
      css_sync_q  <= css_sync_d;
      css_prev_q  <= css_prev_d;
      mosi_meta_q <= mosi_meta_d;
      mosi_sync_q <= mosi_sync_d;
    end
  end

  assign mosi_sync = mosi_sync_q;
  assign beat      = clk_sync_q & ~clk_prev_q & ~css_sync_q;
  assign cs_rise   = css_sync_q & ~css_prev_q;
  assign cs_fall   = ~css_sync_q & css_prev_q;

endmodule

// File: rtl/spi_nor_flash_model.sv
// Byte-parallel SPI NOR flash slave (READ / PROGRAM with NOR bit-clear semantics).
// Define SPI_NOR_WEL_EN to add the WRITE ENABLE latch gating PROGRAM.
module spi_nor_flash_model
  import spi_nor_pkg::*;
#(
  parameter int SPIBITWIDE = 8,
  parameter int MEM_DEPTH  = 256,
  parameter int ADDR_W     = 24
) (
  input  logic                  p_clk,
  input  logic                  p_reset,
  input  logic                  s_clk,
  input  logic                  s_css,
  input  logic [SPIBITWIDE-1:0] s_mosi,
  output logic [SPIBITWIDE-1:0] s_miso,
  output logic                  cmd_err
);

  localparam int IDX_W = $clog2(MEM_DEPTH);

  logic [SPIBITWIDE-1:0] mosi_sync;
  logic                  beat, cs_rise, cs_fall;

  spi_nor_sync_edge #(.W(SPIBITWIDE)) u_sync (
    .p_clk     (p_clk),
    .p_reset   (p_reset),
    .s_clk     (s_clk),
    .s_css     (s_css),
    .s_mosi    (s_mosi),
    .mosi_sync (mosi_sync),
    .beat      (beat),
    .cs_rise   (cs_rise),
    .cs_fall   (cs_fall)
  );

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [1:0]          cnt_q, cnt_d;
  logic                rd_op_q, rd_op_d, prog_op_q, prog_op_d, prog_en_q, prog_en_d;
  logic                err_q, err_d;
  logic                we;
`ifdef SPI_NOR_WEL_EN
  logic                wel_q, wel_d;
`endif

  // Array holds inverted bytes so a zero-initialised RAM reads back as erased 0xFF.
  logic [SPIBITWIDE-1:0] mem_n [MEM_DEPTH];
  logic [SPIBITWIDE-1:0] rd_n_q;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    rd_op_d   = rd_op_q;
    prog_op_d = prog_op_q;
    prog_en_d = prog_en_q;
    err_d     = 1'b0;
    we        = 1'b0;
`ifdef SPI_NOR_WEL_EN
    wel_d     = wel_q;
`endif
    if (cs_rise) begin
      state_d   = ST_IDLE;
      cnt_d     = '0;
      rd_op_d   = 1'b0;
      prog_op_d = 1'b0;
      prog_en_d = 1'b0;
`ifdef SPI_NOR_WEL_EN
      if (prog_op_q) wel_d = 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: if (cs_fall) state_d = ST_CMD;
        ST_CMD: if (beat) begin
          addr_d = '0;
          cnt_d  = '0;
          if (mosi_sync == SPIBITWIDE'(OP_READ)) begin
            rd_op_d = 1'b1;
            state_d = ST_ADDR;
          end else if (mosi_sync == SPIBITWIDE'(OP_PROGRAM)) begin
            prog_op_d = 1'b1;
            state_d   = ST_ADDR;
`ifdef SPI_NOR_WEL_EN
            prog_en_d = wel_q;
            err_d     = ~wel_q;
`else
            prog_en_d = 1'b1;
`endif
          end
`ifdef SPI_NOR_WEL_EN
          else if (mosi_sync == SPIBITWIDE'(OP_WREN)) begin
            wel_d   = 1'b1;
            state_d = ST_IGNORE;
          end
`endif
          else begin
            err_d   = 1'b1;
            state_d = ST_IGNORE;
          end
        end
        ST_ADDR: if (beat) begin
          addr_d = ADDR_W'({addr_q, mosi_sync});
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'(ADDR_BYTES - 1)) state_d = ST_DATA;
        end
        ST_DATA: if (beat) begin
          we     = prog_en_q;
          addr_d = addr_q + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge p_clk or posedge p_reset) begin
    if (p_reset) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      cnt_q     <= '0;
      rd_op_q   <= 1'b0;
      prog_op_q <= 1'b0;
      prog_en_q <= 1'b0;
      err_q     <= 1'b0;
`ifdef SPI_NOR_WEL_EN
      wel_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      rd_op_q   <= rd_op_d;
      prog_op_q <= prog_op_d;
      prog_en_q <= prog_en_d;
      err_q     <= err_d;
`ifdef SPI_NOR_WEL_EN
      wel_q     <= wel_d;
`endif
    end
  end

  // The read port follows the next index, so rd_n_q already holds the old byte
  // at addr_q when a program beat arrives (beats are several cycles apart).
  always_ff @(posedge p_clk) begin
    if (we) mem_n[addr_q[IDX_W-1:0]] <= rd_n_q | ~mosi_sync;
    rd_n_q <= mem_n[addr_d[IDX_W-1:0]];
  end

  assign s_miso  = (state_q == ST_DATA && rd_op_q) ? ~rd_n_q : '0;
  assign cmd_err = err_q;

endmodule

// File: tb/tb_spi_nor_flash_model.sv
// Randomized scoreboard bench for spi_nor_flash_model against a byte-array flash model.
// Honours SPI_NOR_WEL_EN when defined for the build.
module tb_spi_nor_flash_model;
  import spi_nor_pkg::*;

  localparam int DEPTH = 256;

  logic       p_clk = 1'b0;
  logic       p_reset = 1'b1;
  logic       s_clk = 1'b0;
  logic       s_css = 1'b1;
  logic [7:0] s_mosi = 8'h00;
  logic [7:0] s_miso;
  logic       cmd_err;

  always #5 p_clk = ~p_clk;

  spi_nor_flash_model #(.SPIBITWIDE(8), .MEM_DEPTH(DEPTH), .ADDR_W(24)) dut (
    .p_clk   (p_clk),
    .p_reset (p_reset),
    .s_clk   (s_clk),
    .s_css   (s_css),
    .s_mosi  (s_mosi),
    .s_miso  (s_miso),
    .cmd_err (cmd_err)
  );

  int         checks = 0;
  int         errors = 0;
  int         exp_err = 0;
  int         err_seen = 0;
  logic       err_prev = 1'b0;
  logic [7:0] mem_m [DEPTH];
  logic [7:0] wbuf [16];
  logic [7:0] exp_q [$];
  event       smp_ev;
`ifdef SPI_NOR_WEL_EN
  bit         wel_m = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, got, req);
    end
  endtask

  // Scoreboard monitor: every sample request pops one expected s_miso byte.
  initial begin
    logic [7:0] e;
    forever begin
      @(smp_ev);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL miso_unqueued: got %02h, required no sample", s_miso);
      end else begin
        e = exp_q.pop_front();
        $display("sample miso=%02h expected=%02h", s_miso, e);
        if (s_miso !== e) begin
          errors++;
          $display("FAIL miso_byte: got %02h, required %02h", s_miso, e);
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge p_clk);
      if (cmd_err === 1'b1) begin
        err_seen++;
        checks++;
        if (err_prev === 1'b1) begin
          errors++;
          $display("FAIL cmd_err_width: got high for 2+ cycles, required 1-cycle pulse");
        end
      end
      err_prev = cmd_err;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish by 2 ms, required completion");
    $fatal(1, "timeout");
  end

  task automatic spi_start();
    @(negedge p_clk);
    s_css = 1'b0;
    repeat (4) @(negedge p_clk);
  endtask

  task automatic spi_end();
    @(negedge p_clk);
    s_css = 1'b1;
    repeat (6) @(negedge p_clk);
  endtask

  task automatic spi_byte(input logic [7:0] tx, input bit sample);
    @(negedge p_clk);
    s_mosi = tx;
    repeat (3) @(negedge p_clk);
    if (sample) -> smp_ev;
    s_clk = 1'b1;
    repeat (4) @(negedge p_clk);
    s_clk = 1'b0;
    repeat (3) @(negedge p_clk);
  endtask

  // One chip-select frame; limit caps the total bytes sent (abort when reached).
  task automatic do_txn(input logic [7:0] op, input logic [23:0] a, input int n, input int limit);
    int sent;
    int idx;
    bit en;
    sent = 0;
    spi_start();
    if (sent < limit) begin
      spi_byte(op, 1'b0);
      sent++;
      if (op == OP_READ || op == OP_PROGRAM) begin
        en = 1'b1;
`ifdef SPI_NOR_WEL_EN
        if (op == OP_PROGRAM) begin
          en = wel_m;
          if (!wel_m) exp_err++;
        end
`endif
        for (int i = 2; i >= 0; i--) begin
          if (sent < limit) begin
            spi_byte(a[8*i +: 8], 1'b0);
            sent++;
          end
        end
        if (sent == 4) begin
          for (int i = 0; i < n; i++) begin
            if (sent < limit) begin
              idx = (int'(a[7:0]) + i) % DEPTH;
              if (op == OP_READ) begin
                exp_q.push_back(mem_m[idx]);
                spi_byte(8'($urandom), 1'b1);
              end else begin
                spi_byte(wbuf[i], 1'b0);
                if (en) mem_m[idx] = mem_m[idx] & wbuf[i];
              end
              sent++;
            end
          end
        end
`ifdef SPI_NOR_WEL_EN
        if (op == OP_PROGRAM) wel_m = 1'b0;
`endif
      end else begin
`ifdef SPI_NOR_WEL_EN
        if (op == OP_WREN) wel_m = 1'b1;
        else exp_err++;
`else
        exp_err++;
`endif
        for (int i = 0; i < n; i++) begin
          if (sent < limit) begin
            exp_q.push_back(8'h00);
            spi_byte(8'($urandom), 1'b1);
            sent++;
          end
        end
      end
    end
    spi_end();
    $display("txn op=%02h addr=%06h n=%0d sent=%0d", op, a, n, sent);
    chk("cmd_err_count", err_seen, exp_err);
    exp_q.push_back(8'h00);
    -> smp_ev;
    @(negedge p_clk);
  endtask

  task automatic wren();
`ifdef SPI_NOR_WEL_EN
    do_txn(OP_WREN, 24'h0, 0, 99);
`endif
  endtask

  initial begin
    int r;
    logic [7:0] op;
    for (int i = 0; i < DEPTH; i++) mem_m[i] = 8'hFF;
    repeat (4) @(negedge p_clk);
    chk("reset_miso", s_miso, 8'h00);
    chk("reset_cmd_err", cmd_err, 1'b0);
    p_reset = 1'b0;
    repeat (4) @(negedge p_clk);
    chk("post_reset_miso", s_miso, 8'h00);

    // Program/readback pattern
    wren();
    wbuf[0] = 8'hFF; wbuf[1] = 8'h00; wbuf[2] = 8'hFF; wbuf[3] = 8'h00;
    do_txn(OP_PROGRAM, 24'h000000, 4, 99);
    do_txn(OP_READ, 24'h000000, 4, 99);

    // AND semantics: F0 then 0F gives 00
    wren(); wbuf[0] = 8'hF0; do_txn(OP_PROGRAM, 24'h000000, 1, 99);
    wren(); wbuf[0] = 8'h0F; do_txn(OP_PROGRAM, 24'h000000, 1, 99);
    do_txn(OP_READ, 24'h000000, 1, 99);

    // Wrap at the top of the array, also with high address bits set
    do_txn(OP_READ, 24'h0000FF, 3, 99);
    do_txn(OP_READ, 24'h1234FF, 3, 99);

    // Unknown opcode
    do_txn(8'h7E, 24'h0, 4, 99);

    // Abort after two address bytes, then a full read
    do_txn(OP_READ, 24'h000005, 4, 3);
    do_txn(OP_READ, 24'h000000, 4, 99);

    // Program aborted after two data bytes
    wren();
    wbuf[0] = 8'h5A; wbuf[1] = 8'hC3; wbuf[2] = 8'h00; wbuf[3] = 8'h00;
    do_txn(OP_PROGRAM, 24'h00000A, 4, 6);
    do_txn(OP_READ, 24'h000008, 8, 99);

    // PROGRAM without a preceding WREN (rejected only when the latch exists)
    wbuf[0] = 8'h11; wbuf[1] = 8'h22;
    do_txn(OP_PROGRAM, 24'h000020, 2, 99);
    do_txn(OP_READ, 24'h000020, 2, 99);

    // Randomized traffic
    for (int t = 0; t < 50; t++) begin
      r = int'($urandom_range(0, 9));
      if (r < 4) op = OP_READ;
      else if (r < 7) op = OP_PROGRAM;
      else if (r == 7) op = OP_WREN;
      else op = 8'($urandom);
      if (op == OP_PROGRAM && $urandom_range(0, 3) != 0) wren();
      for (int i = 0; i < 16; i++)
        wbuf[i] = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
      do_txn(op, {8'($urandom), 8'($urandom), ($urandom_range(0, 1) == 1) ? 8'hFE : 8'($urandom)},
             int'($urandom_range(1, 5)), ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 8)) : 99);
    end

    // Reset asserted in the middle of a READ data phase
    wren();
    spi_start();
    spi_byte(OP_READ, 1'b0);
    spi_byte(8'h00, 1'b0); spi_byte(8'h00, 1'b0); spi_byte(8'h40, 1'b0);
    exp_q.push_back(mem_m[8'h40]);
    spi_byte(8'h00, 1'b1);
    @(negedge p_clk);
    p_reset = 1'b1;
`ifdef SPI_NOR_WEL_EN
    wel_m = 1'b0;
`endif
    repeat (2) @(negedge p_clk);
    exp_q.push_back(8'h00);
    -> smp_ev;
    s_css = 1'b1;
    repeat (2) @(negedge p_clk);
    p_reset = 1'b0;
    repeat (6) @(negedge p_clk);
    chk("reset_mid_data_miso", s_miso, 8'h00);

    // Latch must be clear after reset
    wbuf[0] = 8'h00;
    do_txn(OP_PROGRAM, 24'h000040, 1, 99);
    do_txn(OP_READ, 24'h000040, 1, 99);

    repeat (10) @(negedge p_clk);
    chk("queue_drained", exp_q.size(), 0);
    chk("cmd_err_total", err_seen, exp_err);
    $display("== %0d vectors applied, %0d miscompares ==", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_nor_flash_model.md
Name: spi_nor_flash_model

Overview:
- Synthesizable byte-parallel SPI NOR flash slave. Sits directly downstream of the APB-to-SPI NOR flash controller and consumes its s_clk / s_css / s_mosi outputs. Drives s_miso back to the controller.
- Replaces the ad-hoc behavioural flash in the controller bench. It is also used on FPGA as a flash stand-in.
- Runs entirely in the p_clk domain and oversamples the SPI pins.

Parameters:
- SPIBITWIDE, 8, width of the s_mosi/s_miso byte bus
- MEM_DEPTH, 256, number of bytes in the array; power of two
- ADDR_W, 24, number of address bits carried by the three address bytes

Ports:
- p_clk  in  1  system clock, also used as the SPI oversampling clock
- p_reset  in  1  asynchronous, active-high reset
- s_clk  in  1  SPI clock from the controller; one rising edge per byte
- s_css  in  1  chip select, active-low
- s_mosi  in  SPIBITWIDE  command/address/write byte from the controller
- s_miso  out  SPIBITWIDE  read byte to the controller
- cmd_err  out  1  one-cycle pulse when an unknown opcode is received or a program is rejected

Behaviour:
- Synchronization and edge detect:
  - s_clk, s_css and s_mosi each pass through a 2-FF synchronizer.
  - A beat is a rising edge of the synchronized s_clk while the synchronized s_css is 0.
  - s_clk high and low phases are each >= 3 p_clk periods. Shorter phases are unsupported.
- Reset values: s_miso = 0; cmd_err = 0; state = IDLE; address and byte counter = 0. The array is not cleared and powers up at 0xFF.
- States: IDLE, CMD, ADDR, DATA, IGNORE.
  - IDLE: a synchronized s_css falling edge moves to CMD.
  - CMD: the beat latches the opcode.
    - 0x01 (READ) or 0x02 (PROGRAM) -> ADDR.
    - Any other opcode -> IGNORE and pulses cmd_err.
  - ADDR: three beats, MSB byte first, assemble addr[ADDR_W-1:0]. The third beat moves to DATA. The effective index is addr mod MEM_DEPTH.
  - DATA, PROGRAM: each beat performs mem[idx] <= mem[idx] & s_mosi_sync. NOR semantics: a program only clears bits. idx then increments.
  - DATA, READ: on entry to DATA, and after every beat, s_miso <= mem[idx]. This happens 1 cycle after the edge detect, so the byte is stable before the next s_clk rising edge. idx increments after each beat.
  - IGNORE: all beats are discarded.
- Address wrap: idx wraps from MEM_DEPTH-1 to 0. The transfer length is unlimited.
- Chip-select release: a synchronized s_css rising edge in any state returns to IDLE on the next cycle and aborts any partial transfer.
  - Bytes already programmed stay programmed.
  - s_miso returns to 0 while in IDLE.
- Simultaneous s_css rise and s_clk rise in the same synchronized cycle: the beat is discarded and deselect wins.
- p_reset asserted mid-operation: the FSM returns to IDLE immediately (asynchronous). A program beat in that cycle is not committed.

Optional Feature:
- Macro: SPI_NOR_WEL_EN.
- When defined:
  - Opcode 0x06 (WRITE ENABLE) sets a write-enable latch (wel) and goes to IGNORE.
  - PROGRAM with wel=0 pulses cmd_err, then takes address bytes but commits no data.
  - wel clears on the s_css rise that ends any PROGRAM transfer, and on reset.
- When undefined:
  - There is no wel.
  - 0x06 is an unknown opcode.
  - PROGRAM is always accepted.

Decomposition:
- Shared package spi_nor_pkg holds:
  - opcode constants OP_READ=8'h01, OP_PROGRAM=8'h02, OP_WREN=8'h06;
  - the state encoding typedef;
  - the ADDR_BYTES=3 constant.
- The controller uses the same opcode constants.
- One sub-module: spi_nor_sync_edge. It holds the 2-FF synchronizers and the rise/fall detectors for s_clk and s_css, and outputs sampled data, beat and cs_rise/cs_fall.

Test Plan:
- PROGRAM 0x02, addr 00 00 00, data FF 00 FF 00 (WEL set if enabled), then READ 0x01 from the same address -> s_miso returns FF 00 FF 00 on beats 5-8.
- PROGRAM 0x0F at addr 0 over existing 0xF0 -> readback is 0x00 (AND semantics).
- READ starting at addr MEM_DEPTH-1 for 3 data beats -> bytes from mem[255], mem[0], mem[1]; no X.
- Opcode 0x7E -> cmd_err pulses once for 1 cycle; subsequent beats ignored; s_miso stays 0.
- s_css deasserted after 2 address bytes, then a full READ from addr 0 -> state was IDLE after the abort; data is correct; no spurious program.
- SPI_NOR_WEL_EN: PROGRAM without 0x06 -> cmd_err pulse and array unchanged. After 0x06 the program commits. Then p_reset asserted mid-DATA -> s_miso=0, state IDLE, wel=0.
